// File: rtl/param_register_bank.sv
// General-purpose register store: DEPTH x WIDTH registers with one read-modify-write
// port (LOAD/INC/DEC) and two combinational read ports with optional write bypass.

module param_register_bank_rd #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
  input  logic [ADDR_W-1:0]           addr,
  input  logic                        we,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [WIDTH-1:0]            nxt,
  output logic [WIDTH-1:0]            data
);
  // Unmatched addresses (>= DEPTH) and a hard-wired zero register fall through to 0.
  always_comb begin
    data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (addr == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0)) data = regs[i];
    if (BYPASS != 0 && we && addr == wr_addr) data = nxt;
  end
endmodule

module param_register_bank #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  parameter int ADDR_W   = (DEPTH <= 2) ? 1 : $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [1:0]        WR_OP,
  input  logic [WIDTH-1:0]  WR_DATA,
  input  logic [ADDR_W-1:0] RD_ADDR_A,
  output logic [WIDTH-1:0]  RD_DATA_A,
  input  logic [ADDR_W-1:0] RD_ADDR_B,
  output logic [WIDTH-1:0]  RD_DATA_B,
  output logic              CARRY
);
  typedef enum logic [1:0] {OP_HOLD = 2'b00, OP_LOAD = 2'b01, OP_INC = 2'b10, OP_DEC = 2'b11} op_e;

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0]            hit;
  logic [WIDTH-1:0]            cur, nxt;
  logic                        we, wrap;
  op_e                         op;

  assign op = op_e'(WR_OP);

  // One-hot decode of the write target; out-of-range and zero-register writes never hit.
  always_comb begin
    hit = '0;
    cur = '0;
    for (int i = 0; i < DEPTH; i++)
      if (WR_ADDR == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0)) begin
        hit[i] = 1'b1;
        cur    = regs[i];
      end
  end

  assign we = ENABLE && (op != OP_HOLD) && (|hit);

  always_comb begin
    nxt  = cur;
    wrap = 1'b0;
    case (op)
      OP_LOAD: nxt = WR_DATA;
      OP_INC: begin
        nxt  = cur + WIDTH'(1);
        wrap = &cur;
      end
      OP_DEC: begin
        nxt  = cur - WIDTH'(1);
        wrap = ~|cur;
      end
      default: nxt = cur;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      regs  <= '0;
      CARRY <= 1'b0;
    end else if (we) begin
      for (int i = 0; i < DEPTH; i++)
        if (hit[i]) regs[i] <= nxt;
      if (op == OP_INC || op == OP_DEC) CARRY <= wrap;
    end
  end

  logic [1:0][ADDR_W-1:0] rd_addr;
  logic [1:0][WIDTH-1:0]  rd_data;

  assign rd_addr   = {RD_ADDR_B, RD_ADDR_A};
  assign RD_DATA_A = rd_data[0];
  assign RD_DATA_B = rd_data[1];

  for (genvar p = 0; p < 2; p++) begin : g_rd
    param_register_bank_rd #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd (
      .regs(regs), .addr(rd_addr[p]), .we(we), .wr_addr(WR_ADDR), .nxt(nxt), .data(rd_data[p])
    );
  end
endmodule
